// File: rtl/dbg_panel.sv
// Debug front panel: synchronizes and debounces raw board controls, tracks the
// panel mode and produces step pulses, breakpoint and memory-view address.
module dbg_panel #(
   parameter int unsigned DB_CYCLES     = 20000,
   parameter int unsigned REPEAT_CYCLES = 4000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_btn_step,
   input  logic        i_btn_up,
   input  logic        i_btn_dn,
   input  logic [1:0]  i_sw_mode,
   input  logic [7:0]  i_sw_bp,
   output logic        o_one_step,
   output logic        o_one_step_en,
   output logic        o_break_en,
   output logic [31:0] o_breakpoint,
   output logic        o_memread_en,
   output logic [7:0]  o_out_addr
);

   localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
   localparam logic [RPW-1:0] RP_MAX = RPW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_STEP    = 2'b01,
      ST_BREAK   = 2'b10,
      ST_MEMVIEW = 2'b11
   } state_t;

   state_t      r_state, w_state_next;
   logic [2:0]  r_btn_s1, r_btn_s2;   // bit 0 step, bit 1 up, bit 2 down
   logic [1:0]  r_mode_s1, r_mode_s2;
   logic [7:0]  r_bp_s1, r_bp_s2, r_bp;
   logic [2:0]  w_db, r_db_d, w_press;
   logic [1:0]  w_rep;
   logic        r_one_step;
   logic [7:0]  r_addr;
   logic        w_mv, w_up, w_dn;
   logic        w_one_step_en, w_break_en, w_memread_en;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_btn_s1  <= '0;
         r_btn_s2  <= '0;
         r_mode_s1 <= '0;
         r_mode_s2 <= '0;
         r_bp_s1   <= '0;
         r_bp_s2   <= '0;
      end else begin
         r_btn_s1  <= {i_btn_dn, i_btn_up, i_btn_step};
         r_btn_s2  <= r_btn_s1;
         r_mode_s1 <= i_sw_mode;
         r_mode_s2 <= r_mode_s1;
         r_bp_s1   <= i_sw_bp;
         r_bp_s2   <= r_bp_s1;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_db
      logic           r_db;
      logic [DBW-1:0] r_cnt;
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
         end else if (r_btn_s2[g] == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_MAX) begin
            r_db  <= r_btn_s2[g];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DBW'(1);
         end
      end
      assign w_db[g] = r_db;
   end

   assign w_press = w_db & ~r_db_d;
   assign w_mv    = (w_state_next == ST_MEMVIEW);

   // Hold counters follow the incoming state so a mode change cancels repeats at once.
   for (genvar g = 0; g < 2; g++) begin : g_hold
      logic [RPW-1:0] r_hold;
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst)
            r_hold <= '0;
         else if (!w_db[g+1] || !w_mv || r_hold == RP_MAX)
            r_hold <= '0;
         else
            r_hold <= r_hold + RPW'(1);
      end
      assign w_rep[g] = w_db[g+1] && w_mv && (r_hold == RP_MAX);
   end

   always_comb begin
      w_state_next  = state_t'(r_mode_s2);
      w_one_step_en = 1'b0;
      w_break_en    = 1'b0;
      w_memread_en  = 1'b0;
      case (r_state)
         ST_STEP:    w_one_step_en = 1'b1;
         ST_BREAK:   w_break_en    = 1'b1;
         ST_MEMVIEW: begin
            w_one_step_en = 1'b1;
            w_memread_en  = 1'b1;
         end
         default:    ;
      endcase
   end

   assign w_up = (w_press[1] | w_rep[0]) & w_mv;
   assign w_dn = (w_press[2] | w_rep[1]) & w_mv;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_RUN;
         r_db_d     <= '0;
         r_one_step <= 1'b0;
         r_addr     <= '0;
         r_bp       <= '0;
      end else begin
         r_state    <= w_state_next;
         r_db_d     <= w_db;
         r_one_step <= w_press[0] && (w_state_next == ST_STEP);
         r_bp       <= r_bp_s2;
         if (w_up && !w_dn)
            r_addr <= r_addr + 8'd1;
         else if (w_dn && !w_up)
            r_addr <= r_addr - 8'd1;
      end
   end

   assign o_one_step    = r_one_step;
   assign o_one_step_en = w_one_step_en;
   assign o_break_en    = w_break_en;
   assign o_memread_en  = w_memread_en;
   assign o_breakpoint  = {22'b0, r_bp, 2'b00};
   assign o_out_addr    = r_addr;

endmodule
